addsub_accum_ctrl: RTL and testbench

// - Sequential front end for the combinational 4-bit adder/subtractor (addSub4).
// - Accepts opcode+operand commands over a valid/ready handshake.
// - Drives the adder's av/bv/M inputs from an internal accumulator, then captures

---
 rtl/addsub_pkg.sv | 6 +
 rtl/addsub_accum_ctrl_if.sv | 21 ++
 rtl/addsub_flags.sv | 12 +
 rtl/addsub_accum_ctrl.sv | 77 +++++++
 tb/tb_addsub_accum_ctrl.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/addsub_pkg.sv
// addsub_pkg: shared opcode/state encodings and datapath width for the accumulator front end.
package addsub_pkg;
  typedef enum logic [1:0] {OP_LOAD, OP_ADD, OP_SUB, OP_CLEAR} op_e;
  typedef enum logic [1:0] {IDLE, EXEC, WB, RESP} state_e;
  localparam int ADDSUB_WIDTH = 4;
endpackage

// File: rtl/addsub_accum_ctrl_if.sv
// addsub_accum_ctrl_if: command and response handshakes of the accumulator controller.
interface addsub_accum_ctrl_if #(parameter int WIDTH = 4, parameter int CNT_WIDTH = 8);
  logic                 in_valid;
  logic                 in_ready;
  logic [1:0]           in_op;
  logic [WIDTH-1:0]     in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     acc_out;
  logic                 carry_flag;
  logic                 ovf_flag;
  logic [CNT_WIDTH-1:0] op_count;
  modport master (
    output in_valid, in_op, in_data, out_ready,
    input  in_ready, out_valid, acc_out, carry_flag, ovf_flag, op_count
  );
  modport slave (
    input  in_valid, in_op, in_data, out_ready,
    output in_ready, out_valid, acc_out, carry_flag, ovf_flag, op_count
  );
endinterface

// File: rtl/addsub_flags.sv
// addsub_flags: two's-complement overflow from the sign bits of a, b, result and the subtract select.
module addsub_flags (
  input  logic a,
  input  logic b,
  input  logic m,
  input  logic r,
  output logic ovf
);
  logic be;
  assign be  = m ^ b;
  assign ovf = (a == be) && (r != a);
endmodule

// File: rtl/addsub_accum_ctrl.sv
// addsub_accum_ctrl: handshake-driven accumulator sequencing an external 4-bit adder/subtractor.
module addsub_accum_ctrl
  import addsub_pkg::*;
#(
  parameter int WIDTH     = ADDSUB_WIDTH,
  parameter int CNT_WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  addsub_accum_ctrl_if.slave bus,
  output logic [WIDTH-1:0] av_o,
  output logic [WIDTH-1:0] bv_o,
  output logic             m_o,
  input  logic [WIDTH-1:0] resultv_i,
  input  logic             cout_i
);
  state_e               state, nstate;
  op_e                  op_q;
  logic [WIDTH-1:0]     data_q, acc;
  logic                 carry, ovf, ovf_n, accept, in_arith, q_arith;
  logic [CNT_WIDTH-1:0] cnt;
  // ADD (01) and SUB (10) are the only opcodes whose bits differ
  assign in_arith = ^bus.in_op;
  assign q_arith  = (op_q == OP_ADD) || (op_q == OP_SUB);
  assign accept   = bus.in_valid && bus.in_ready;
  always_comb begin
    nstate = state;
    nstate = state == IDLE ? (bus.in_valid ? (in_arith ? EXEC : WB) : IDLE)
           : state == EXEC ? WB
           : state == WB   ? RESP
           : (bus.out_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      op_q   <= OP_LOAD;
      data_q <= '0;
      acc    <= '0;
      carry  <= 1'b0;
      ovf    <= 1'b0;
      cnt    <= '0;
      av_o   <= '0;
      bv_o   <= '0;
      m_o    <= 1'b0;
    end else begin
      state <= nstate;
      if (accept) begin
        op_q   <= op_e'(bus.in_op);
        data_q <= bus.in_data;
      end
      if (accept && in_arith) begin
        av_o <= acc;
        bv_o <= bus.in_data;
        m_o  <= bus.in_op == OP_SUB;
      end
      if (state == WB) begin
        acc   <= q_arith ? resultv_i : (op_q == OP_LOAD ? data_q : '0);
        carry <= q_arith && cout_i;
        ovf   <= q_arith && ovf_n;
        cnt   <= &cnt ? cnt : cnt + 1'b1;
      end
    end
  end
  addsub_flags u_flags (
    .a  (av_o[WIDTH-1]),
    .b  (bv_o[WIDTH-1]),
    .m  (m_o),
    .r  (resultv_i[WIDTH-1]),
    .ovf(ovf_n)
  );
  assign bus.in_ready   = state == IDLE;
  assign bus.out_valid  = state == RESP;
  assign bus.acc_out    = acc;
  assign bus.carry_flag = carry;
  assign bus.ovf_flag   = ovf;
  assign bus.op_count   = cnt;
endmodule

// File: tb/tb_addsub_accum_ctrl.sv
// tb_addsub_accum_ctrl: directed scoreboard bench with a behavioural adder/subtractor in the loop.
module tb_addsub_accum_ctrl;
  import addsub_pkg::*;
  typedef struct packed {
    logic [3:0] acc;
    logic       c;
    logic       v;
    logic [7:0] cnt;
  } exp_t;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] av, bv, res;
  logic       m, cout;
  exp_t       q[$];
  logic [3:0] macc;
  logic [7:0] mcnt;
  int         checks = 0;
  int         failures = 0;
  always #5 clk = ~clk;
  addsub_accum_ctrl_if #(.WIDTH(4), .CNT_WIDTH(8)) bus ();
  assign {cout, res} = {1'b0, av} + {1'b0, (m ? ~bv : bv)} + {4'b0, m};
  addsub_accum_ctrl #(.WIDTH(4), .CNT_WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .av_o     (av),
    .bv_o     (bv),
    .m_o      (m),
    .resultv_i(res),
    .cout_i   (cout)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send(input op_e op, input logic [3:0] d);
    logic [4:0] s;
    exp_t       e;
    int         n;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_data  = d;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", bus.in_ready, 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    e.c = 1'b0;
    e.v = 1'b0;
    if (op == OP_ADD) begin
      s   = {1'b0, macc} + {1'b0, d};
      e.c = s[4];
      e.v = (macc[3] == d[3]) && (s[3] != macc[3]);
    end else if (op == OP_SUB) begin
      s   = {1'b0, macc} - {1'b0, d};
      e.c = macc >= d;
      e.v = (macc[3] != d[3]) && (s[3] != macc[3]);
    end else begin
      s = (op == OP_LOAD) ? {1'b0, d} : 5'd0;
    end
    macc  = s[3:0];
    mcnt  = (mcnt == 8'hff) ? mcnt : mcnt + 8'd1;
    e.acc = macc;
    e.cnt = mcnt;
    q.push_back(e);
  endtask
  task automatic recv(input int lat, input int hold, input bit offer, input logic expm);
    exp_t e;
    int   n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1 && lat == 3) chk("m_exec", m, expm);
    end while (!bus.out_valid && n < 10);
    chk("latency", n, lat);
    chk("in_ready_busy", bus.in_ready, 0);
    chk("sb_size", q.size(), 1);
    e = (q.size() > 0) ? q.pop_front() : '0;
    chk("acc_out", bus.acc_out, e.acc);
    chk("carry_flag", bus.carry_flag, e.c);
    chk("ovf_flag", bus.ovf_flag, e.v);
    chk("op_count", bus.op_count, e.cnt);
    if (offer) begin
      bus.in_valid = 1'b1;
      bus.in_op    = OP_CLEAR;
      bus.in_data  = 4'hf;
    end
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_acc", bus.acc_out, e.acc);
      chk("hold_carry", bus.carry_flag, e.c);
      chk("hold_ovf", bus.ovf_flag, e.v);
      chk("hold_in_ready", bus.in_ready, 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    chk("out_valid_drop", bus.out_valid, 0);
    chk("idle_ready", bus.in_ready, 1);
  endtask
  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_op     = OP_LOAD;
    bus.in_data   = 4'h0;
    bus.out_ready = 1'b0;
    macc          = 4'h0;
    mcnt          = 8'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_acc", bus.acc_out, 0);
    chk("rst_count", bus.op_count, 0);
    chk("rst_flags", {bus.carry_flag, bus.ovf_flag}, 0);
    chk("rst_adder_in", {av, bv, m}, 0);
    send(OP_LOAD, 4'd5);  recv(2, 0, 1'b0, 1'b0);
    send(OP_ADD, 4'd11);  recv(3, 0, 1'b0, 1'b0);
    chk("add_wrap_acc", bus.acc_out, 0);
    chk("add_wrap_carry", bus.carry_flag, 1);
    send(OP_LOAD, 4'd3);  recv(2, 0, 1'b0, 1'b0);
    send(OP_SUB, 4'd5);   recv(3, 0, 1'b0, 1'b1);
    chk("sub_borrow_acc", bus.acc_out, 4'he);
    send(OP_LOAD, 4'd7);  recv(2, 0, 1'b0, 1'b0);
    send(OP_ADD, 4'd1);   recv(3, 0, 1'b0, 1'b0);
    chk("add_ovf", bus.ovf_flag, 1);
    send(OP_LOAD, 4'd8);  recv(2, 0, 1'b0, 1'b0);
    send(OP_SUB, 4'd1);   recv(3, 0, 1'b0, 1'b1);
    chk("sub_ovf_acc", bus.acc_out, 4'd7);
    send(OP_ADD, 4'd4);   recv(3, 5, 1'b1, 1'b0);
    send(OP_CLEAR, 4'd9); recv(2, 0, 1'b0, 1'b0);
    send(OP_LOAD, 4'd6);  recv(2, 0, 1'b0, 1'b0);
    send(OP_ADD, 4'd2);
    q.delete();
    @(negedge clk);
    chk("exec_av", av, 4'd6);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    macc = 4'h0;
    mcnt = 8'h0;
    @(negedge clk);
    chk("midop_acc", bus.acc_out, 0);
    chk("midop_out_valid", bus.out_valid, 0);
    chk("midop_in_ready", bus.in_ready, 1);
    chk("midop_count", bus.op_count, 0);
    send(OP_LOAD, 4'd9);  recv(2, 0, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
